carry_skip_sequencer: RTL and testbench



---
 rtl/carry_skip_sequencer_pkg.sv | 15 +
 rtl/carry_skip_sequencer_skip_slice.sv | 17 +
 rtl/carry_skip_sequencer.sv | 131 +++++++++++++
 tb/tb_carry_skip_sequencer.sv | 127 ++++++++++++
 4 files changed

// File: rtl/carry_skip_sequencer_pkg.sv
// carry_skip_sequencer_pkg: shared state encoding and derived-width helpers
package carry_skip_sequencer_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  localparam int N_DEF = 32;
  localparam int SLICE_DEF = 4;
  function automatic int nslice(int n, int s);
    return n / s;
  endfunction
  function automatic int idx_w(int ns);
    return ns > 1 ? $clog2(ns) : 1;
  endfunction
  function automatic int skip_w(int ns);
    return $clog2(ns) + 1;
  endfunction
endpackage

// File: rtl/carry_skip_sequencer_skip_slice.sv
// skip_slice: one SLICE-bit adder slice with carry-skip bypass
module skip_slice #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         p,
  output logic         cout
);
  logic [W:0] r;
  assign r = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  assign s = r[W-1:0];
  assign p = &(a ^ b);
  assign cout = p ? cin : r[W];
endmodule

// File: rtl/carry_skip_sequencer.sv
// carry_skip_sequencer: round-robin arbitrated serial carry-skip adder
module carry_skip_sequencer
  import carry_skip_sequencer_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int SLICE = SLICE_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [1:0]                    Req,
  input  logic [N-1:0]                  A0,
  input  logic [N-1:0]                  B0,
  input  logic [N-1:0]                  A1,
  input  logic [N-1:0]                  B1,
  output logic [1:0]                    Gnt,
  output logic                          Busy,
  output logic                          Valid,
  output logic [N-1:0]                  Sum,
  output logic                          Cout,
  output logic                          Overflow,
  output logic                          Id,
  output logic [$clog2(N/SLICE):0]      SkipCnt
);
  localparam int NS = nslice(N, SLICE);
  localparam int IW = idx_w(NS);
  localparam int SW = skip_w(NS);
  if (N % SLICE != 0) begin : g_bad_width
    $error("N must be a multiple of SLICE");
  end
  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [SW-1:0] acc_q, acc_d, skip_q, skip_d;
  logic [N-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d, id_q, id_d;
  logic ptr_q, ptr_d, busy_q, busy_d, valid_q, valid_d;
  logic [SLICE-1:0] sl_s;
  logic sl_p, sl_c;
  skip_slice #(.W(SLICE)) u_slice (
    .a(a_q[idx_q*SLICE +: SLICE]),
    .b(b_q[idx_q*SLICE +: SLICE]),
    .cin(carry_q),
    .s(sl_s),
    .p(sl_p),
    .cout(sl_c)
  );
  // arbitration, slice stepping and result capture
  always_comb begin
    Gnt = state_q == IDLE ? (Req == 2'b11 ? (ptr_q ? 2'b10 : 2'b01) : Req) : 2'b00;
    state_d = state_q;
    idx_d = idx_q;
    acc_d = acc_q;
    skip_d = skip_q;
    a_d = a_q;
    b_d = b_q;
    sum_d = sum_q;
    carry_d = carry_q;
    cout_d = cout_q;
    ovf_d = ovf_q;
    id_d = id_q;
    ptr_d = ptr_q;
    busy_d = busy_q;
    valid_d = 1'b0;
    if (state_q == IDLE && |Gnt) begin
      state_d = RUN;
      a_d = Gnt[1] ? A1 : A0;
      b_d = Gnt[1] ? B1 : B0;
      carry_d = 1'b0;
      idx_d = '0;
      acc_d = '0;
      ptr_d = ~Gnt[1];
      id_d = Gnt[1];
      busy_d = 1'b1;
    end else if (state_q == RUN) begin
      sum_d[idx_q*SLICE +: SLICE] = sl_s;
      carry_d = sl_c;
      acc_d = acc_q + SW'(sl_p);
      idx_d = idx_q + 1'b1;
      if (idx_q == IW'(NS - 1)) begin
        state_d = DONE;
        valid_d = 1'b1;
        cout_d = sl_c;
        ovf_d = (a_q[N-1] == b_q[N-1]) && (sum_d[N-1] != a_q[N-1]);
        skip_d = acc_d;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
      busy_d = 1'b0;
    end
  end
  // state and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      acc_q <= '0;
      skip_q <= '0;
      a_q <= '0;
      b_q <= '0;
      sum_q <= '0;
      carry_q <= 1'b0;
      cout_q <= 1'b0;
      ovf_q <= 1'b0;
      id_q <= 1'b0;
      ptr_q <= 1'b0;
      busy_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      acc_q <= acc_d;
      skip_q <= skip_d;
      a_q <= a_d;
      b_q <= b_d;
      sum_q <= sum_d;
      carry_q <= carry_d;
      cout_q <= cout_d;
      ovf_q <= ovf_d;
      id_q <= id_d;
      ptr_q <= ptr_d;
      busy_q <= busy_d;
      valid_q <= valid_d;
    end
  end
  assign Busy = busy_q;
  assign Valid = valid_q;
  assign Sum = sum_q;
  assign Cout = cout_q;
  assign Overflow = ovf_q;
  assign Id = id_q;
  assign SkipCnt = skip_q;
endmodule

// File: tb/tb_carry_skip_sequencer.sv
// tb_carry_skip_sequencer: directed and random checks against an arithmetic model
module tb_carry_skip_sequencer;
  logic clk = 1'b0;
  logic rst;
  logic [1:0] req;
  logic [31:0] a0, b0, a1, b1;
  logic [1:0] gnt;
  logic busy, valid, cout, ovf, id;
  logic [31:0] sum;
  logic [3:0] skip;
  int checks = 0;
  int fails = 0;
  bit ptr_m = 1'b0;

  carry_skip_sequencer dut (
    .clk(clk), .rst(rst), .Req(req),
    .A0(a0), .B0(b0), .A1(a1), .B1(b1),
    .Gnt(gnt), .Busy(busy), .Valid(valid), .Sum(sum),
    .Cout(cout), .Overflow(ovf), .Id(id), .SkipCnt(skip)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [1:0] r, input logic [31:0] x0, y0, x1, y1, input bit hold);
    logic [31:0] a, b, d;
    logic [32:0] full;
    int w, cyc, sk;
    req = r; a0 = x0; b0 = y0; a1 = x1; b1 = y1;
    #1;
    w = (r == 2'b11) ? int'(ptr_m) : int'(r == 2'b10);
    chk("gnt", gnt, w ? 2'b10 : 2'b01);
    ptr_m = !w;
    a = w ? x1 : x0;
    b = w ? y1 : y0;
    tick;
    if (!hold) req = 2'b00;
    a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
    chk("busy_run", busy, 1);
    cyc = 1;
    while (!valid && cyc < 30) begin
      tick;
      cyc++;
    end
    chk("latency", cyc, 9);
    full = {1'b0, a} + {1'b0, b};
    d = a ^ b;
    sk = 0;
    for (int k = 0; k < 8; k++) if (((d >> (4 * k)) & 32'hF) == 32'hF) sk++;
    chk("sum", sum, full[31:0]);
    chk("cout", cout, full[32]);
    chk("overflow", ovf, (a[31] == b[31]) && (full[31] != a[31]));
    chk("id", id, w);
    chk("skipcnt", skip, sk);
    tick;
    chk("valid_pulse", valid, 0);
    chk("sum_hold", sum, full[31:0]);
  endtask

  initial begin
    int seen;
    logic [31:0] x, y;
    rst = 1'b1; req = 2'b00; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    tick;
    tick;
    rst = 1'b0;
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_gnt", gnt, 0);
    chk("rst_sum", sum, 0);
    chk("rst_flags", {cout, ovf, id}, 0);
    chk("rst_skip", skip, 0);
    run_op(2'b01, 32'h00000001, 32'h00000001, 32'h0, 32'h0, 0);
    run_op(2'b10, 32'h0, 32'h0, 32'hFFFFFFFF, 32'h00000000, 0);
    run_op(2'b01, 32'h7FFFFFFF, 32'h00000001, 32'h0, 32'h0, 0);
    run_op(2'b01, 32'hFFFFFFFF, 32'h00000001, 32'h0, 32'h0, 0);
    run_op(2'b11, 32'h80000000, 32'h80000000, 32'h12345678, 32'h9ABCDEF0, 1);
    run_op(2'b11, 32'h0000FFFF, 32'h00000001, 32'h7FFF0000, 32'h7FFF0000, 1);
    run_op(2'b11, 32'hDEADBEEF, 32'h21524110, 32'h1, 32'h2, 1);
    req = 2'b00;
    tick;
    req = 2'b01; a0 = 32'h0F0F0F0F; b0 = 32'h10101010;
    #1;
    chk("gnt_abort", gnt, 2'b01);
    tick;
    req = 2'b00;
    tick;
    tick;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    ptr_m = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_sum", sum, 0);
    chk("abort_valid", valid, 0);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (valid) seen++;
      tick;
    end
    chk("abort_no_valid", seen, 0);
    run_op(2'b11, 32'h00000005, 32'h00000007, 32'h3, 32'h4, 0);
    for (int i = 0; i < 24; i++) begin
      x = $urandom;
      y = $urandom_range(0, 1) ? (~x ^ ($urandom & 32'h0F0F00F0)) : $urandom;
      if (i % 2 == 0)
        run_op(2'($urandom_range(1, 3)), x, y, $urandom, $urandom, 0);
      else
        run_op(2'($urandom_range(1, 3)), $urandom, $urandom, x, y, 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
